// File: rtl/uart_tx_frame_ctrl_if.sv
// Parallel request and serial line signals of the UART TX framing controller.
// master = upstream byte source, slave = framing controller.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_Data;
    logic                  Data_Valid;
    logic                  Parity_EN;
    logic                  Parity_bit;
    logic                  TX_OUT;
    logic                  Busy;
    logic                  Frame_Done;

    modport master (
        output P_Data,
        output Data_Valid,
        output Parity_EN,
        output Parity_bit,
        input  TX_OUT,
        input  Busy,
        input  Frame_Done
    );

    modport slave (
        input  P_Data,
        input  Data_Valid,
        input  Parity_EN,
        input  Parity_bit,
        output TX_OUT,
        output Busy,
        output Frame_Done
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX framing: start bit, DATA_WIDTH data bits LSB-first, optional parity, stop bit.
// One clk cycle per bit; every output is registered.
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_frame_ctrl_if.slave bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en;
    logic                  tx_out;
    logic                  busy;
    logic                  frame_done;

    assign bus.TX_OUT     = tx_out;
    assign bus.Busy       = busy;
    assign bus.Frame_Done = frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            par_en     <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                // STOP accepts like IDLE so back-to-back frames need no idle gap
                IDLE, STOP: begin
                    tx_out     <= 1'b1;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                    state      <= IDLE;
                    if (bus.Data_Valid) begin
                        shreg  <= bus.P_Data;
                        par_en <= bus.Parity_EN;
                        tx_out <= 1'b0;
                        busy   <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    tx_out  <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en) begin
                            tx_out <= bus.Parity_bit;
                            state  <= PARITY;
                        end else begin
                            tx_out     <= 1'b1;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= STOP;
                        end
                    end else begin
                        tx_out  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    tx_out     <= 1'b1;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= STOP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx_frame_ctrl.md
# uart_tx_frame_ctrl

Transmit framing controller for the UART TX path. Accepts a parallel byte on a valid strobe and serializes one frame onto the line: start bit, 8 data bits LSB-first, optional parity bit, stop bit. Sits downstream of the parity calculator and consumes its registered `Parity_bit`. Runs on the TX bit clock, where one `clk` cycle equals one bit period.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: data bits per frame. The only verified value is 8.

Ports:
- `clk`  in  1  TX bit clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `P_Data`  in  DATA_WIDTH  byte to send; sampled only on accept.
- `Data_Valid`  in  1  single-cycle or held request; the same strobe also drives the parity calculator's `Valid_Data`.
- `Parity_EN`  in  1  include the parity bit; sampled only on accept.
- `Parity_bit`  in  1  registered parity from the parity calculator; sampled in the PARITY state.
- `TX_OUT`  out  1  registered serial line output; idle level is 1.
- `Busy`  out  1  registered; high while a frame occupies the line, excluding its stop bit.
- `Frame_Done`  out  1  registered one-cycle pulse during the stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. A 3-bit bit counter and a data shift register hold the frame; `Parity_EN` is latched on accept.
- **Accept:** a rising edge where `Data_Valid`=1 and the state is IDLE or STOP.
  - Latches `P_Data` and `Parity_EN`.
  - Moves to START and drives `TX_OUT`=0 and `Busy`=1.
  - `Data_Valid` in any other state is ignored; the frame in flight is unaffected.
  - Upstream must not assert `Data_Valid` while `Busy`=1. Doing so corrupts the calculator's `Parity_bit` for the current frame. This block does not guard against it.
- **START → DATA:** `TX_OUT`=D0; counter=0.
- **DATA:** each edge shifts out the next bit (D1..D7) and increments the counter. The edge after D7 goes to PARITY if the latched `Parity_EN`=1, else to STOP.
- **PARITY:** `TX_OUT`=`Parity_bit` as sampled at that edge. Next state is STOP.
- **STOP:**
  - Entry drives `TX_OUT`=1, `Busy`=0, `Frame_Done`=1.
  - Next edge: accept if `Data_Valid`=1 (back-to-back frames with no idle gap), else go to IDLE with `TX_OUT` held at 1.
- **IDLE:** `TX_OUT`=1, `Busy`=0, `Frame_Done`=0.
- **Reset:** a synchronous `rst` wins over everything, including mid-frame.
  - State goes to IDLE and the counter to 0.
  - Outputs take their reset values at the next edge: `TX_OUT`=1, `Busy`=0, `Frame_Done`=0.
  - No partial frame resumes after reset.

## Timing
- Let E0 be the accept edge.
- Line sequence after each edge:
  - After E0: start bit, 0.
  - After E1..E8: D0..D7.
  - After E9: parity (if enabled).
  - After E10: stop bit (or after E9 when parity is disabled).
- Frame length is 11 cycles with parity, 10 without.
- `Parity_bit` is updated by the calculator at E0 and sampled at E9, so the 9-cycle margin is always met.
- `Busy` rises at E0 and falls at the stop-bit edge.
- `Frame_Done` is high for exactly the stop-bit cycle.
- The earliest next accept is the edge ending the stop bit. Minimum frame-to-frame period is 11 cycles with parity, 10 without.
- All outputs change only on `clk` rising edges; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `Data_Valid`=1 → `TX_OUT`=1, `Busy`=0, `Frame_Done`=0 throughout. After release with `Data_Valid`=0, the state stays IDLE.
- **Even-parity frame:** `P_Data`=0xA5, `Parity_EN`=1, even parity, single-cycle `Data_Valid` → `TX_OUT` = 0,1,0,1,0,0,1,0,1,0,1. `Busy` is high for 10 cycles. `Frame_Done` pulses once, on the 11th cycle.
- **Parity disabled:** `P_Data`=0x01, `Parity_EN`=0 → `TX_OUT` = 0,1,0,0,0,0,0,0,0,1 (10 cycles); the parity slot is absent.
- **Back-to-back:** 0x0F (odd parity), with `Data_Valid` asserted during the first frame's stop cycle for 0xF0 → second start bit is on the cycle immediately after the stop bit, with no idle gap.
  - First frame parity bit is 1 (odd parity over 0x0F).
  - Second frame carries D7..D0 of 0xF0 correctly.
- **Ignored request:** pulse `Data_Valid` with `P_Data`=0xFF at cycle 4 of a 0x00 frame, with parity disabled in the bench model → the frame still sends 0x00, and no extra frame follows.
- **Reset mid-frame:** assert `rst` during D3 → after the next edge, `TX_OUT`=1 and `Busy`=0. A new 0x3C frame then transmits correctly from its start bit.
